encoder_pulse_conditioner: RTL
==============================

Name: encoder_pulse_conditioner

Overview:
- Front-end stage for the grating measurement path.
- Takes raw asynchronous encoder channels A, B and Z, then synchronizes, glitch-filters and quadrature-decodes them.
- Emits single-cycle count and index strobes plus a signed-direction position count.
- Its oPulseA and oPulseZ outputs drive the measurement/grouping logic's signal-A and zero-index inputs directly.

Parameters:
- FILTER_LEN, 4: consecutive stable cycles required before a filtered level changes; legal range 1..255.
- POS_W, 16: width of the position counter.
- Z_CLEARS_POS, 0: when 1, a Z strobe loads the position counter with 0.

Ports:
- CLOCK_50M  in  1  system clock, 50 MHz.
- RST_n  in  1  asynchronous active-low reset.
- iA_raw  in  1  raw encoder channel A, asynchronous.
- iB_raw  in  1  raw encoder channel B, asynchronous.
- iZ_raw  in  1  raw encoder index Z, asynchronous.
- iClear  in  1  synchronous clear of position and error.
- oPulseA  out  1  one-cycle count strobe.
- oDir  out  1  direction of last valid count: 1 = forward, 0 = reverse.
- oPulseZ  out  1  one-cycle index strobe.
- oPosition  out  POS_W  up/down position count.
- oQuadErr  out  1  sticky illegal-transition flag.
- oLevelABZ  out  3  filtered levels {A,B,Z}, for debug.

Behaviour:
- Reset: on RST_n low, every flop clears immediately. All outputs are 0, filtered levels are 0, filter counters are 0, primed = 0.
- Sync: each raw input passes through two flops clocked by CLOCK_50M before any other use.
- Glitch filter, per channel:
  - While the synced input differs from the filtered level, the counter increments.
  - When the counter reaches FILTER_LEN, the filtered level takes the synced value and the counter clears.
  - Any cycle where synced equals filtered clears the counter.
  - A pulse shorter than FILTER_LEN cycles never reaches the filtered level.
- Latency: a raw edge held stable appears on oLevelABZ FILTER_LEN+2 cycles later. The resulting strobe is registered one cycle after that (FILTER_LEN+3 total).
- Priming:
  - A counter runs for FILTER_LEN+3 cycles after reset release, then sets primed.
  - Until primed, filtered levels track inputs but no strobes, position changes or errors are generated.
  - This prevents spurious edges when inputs are already high at reset release.
- Quadrature decode (1x, default build):
  - Forward sequence {A,B}: 00 -> 10 -> 11 -> 01 -> 00.
  - On a filtered A rising edge, oPulseA = 1 for one cycle.
  - oDir is registered as ~B_filtered: B low = forward.
- Illegal transition: filtered A and B both change in the same cycle. oQuadErr is set and stays set; no strobe is issued and position is unchanged that cycle.
- Position:
  - Increments on a forward strobe and decrements on a reverse strobe.
  - Wraps modulo 2^POS_W in both directions: max+1 -> 0, 0-1 -> max.
- Index: a filtered Z rising edge gives oPulseZ = 1 for one cycle, aligned with the cycle oPulseA would be for an edge at the same time. oPulseA and oPulseZ may both be high in one cycle.
- Priority on oPosition in the same cycle, highest first:
  1. iClear: position = 0 and oQuadErr = 0.
  2. Z with Z_CLEARS_POS = 1: position = 0.
  3. Count strobe.
- Mid-operation reset: all state is discarded and priming restarts; a strobe in flight is lost.

Optional Feature:
- Macro: QUAD_X4_EN.
- Defined: 4x decode. Every valid filtered edge of A or B produces an oPulseA strobe.
  - Direction follows the sequence table: forward transitions are 00->10, 10->11, 11->01, 01->00; the reverse of each counts down.
  - Position changes by 1 per edge.
- Undefined: 1x decode as described above. Only the filtered A rising edge counts; B edges only update oDir qualification.
- The illegal-transition rule applies in both builds.

Test Plan:
1. Reset release with iA_raw = iB_raw = iZ_raw = 1 held, FILTER_LEN = 4 -> no oPulseA/oPulseZ ever; oLevelABZ = 3'b111 by cycle 6; oPosition = 0.
2. Forward quadrature, 20 cycles per phase, 10 full cycles, 1x build -> exactly 10 oPulseA strobes, each one cycle wide; oDir = 1; oPosition = 10. First strobe arrives exactly 7 cycles after the first A raw rise.
3. Reverse sequence of 3 cycles starting from oPosition = 0, POS_W = 16 -> oPosition = 16'hFFFD; oDir = 0.
4. 3-cycle glitch on iA_raw, FILTER_LEN = 4 -> no filtered change and no strobe. A 4-cycle-stable change -> exactly one strobe.
5. Force A and B to toggle in the same raw cycle -> oQuadErr = 1, oPosition unchanged. Then iClear for 1 cycle -> oQuadErr = 0, oPosition = 0.
6. Z_CLEARS_POS = 1 with position 37, Z rise coincident with a forward A rise -> oPulseZ = 1 and oPulseA = 1 in the same cycle; oPosition = 0 next cycle. With QUAD_X4_EN defined, one full forward cycle -> +4.

Source files
------------

// File: rtl/encoder_pulse_conditioner.sv
// Encoder front end: 2-flop sync, glitch filter, 1x quadrature decode (4x when QUAD_X4_EN is defined).
// Latency: raw edge -> oLevelABZ in FILTER_LEN+2 cycles, -> oPulseA/oPulseZ in FILTER_LEN+3 cycles.
// Backpressure: none; strobes are single-cycle and never held off.
module encoder_pulse_conditioner #(
  parameter int FILTER_LEN   = 4,
  parameter int POS_W        = 16,
  parameter int Z_CLEARS_POS = 0
) (
  input  logic             CLOCK_50M,
  input  logic             RST_n,
  input  logic             iA_raw,
  input  logic             iB_raw,
  input  logic             iZ_raw,
  input  logic             iClear,
  output logic             oPulseA,
  output logic             oDir,
  output logic             oPulseZ,
  output logic [POS_W-1:0] oPosition,
  output logic             oQuadErr,
  output logic [2:0]       oLevelABZ
);

  localparam logic [7:0] FLT_LAST   = 8'(FILTER_LEN - 1);
  localparam logic [8:0] PRIME_LAST = 9'(FILTER_LEN + 2);
  localparam bit         Z_CLR      = (Z_CLEARS_POS != 0);

  // Channel bit order everywhere: [2] = A, [1] = B, [0] = Z.
  logic [2:0]      sync_1;
  logic [2:0]      sync_2;
  logic [2:0]      filt;
  logic [2:0]      filt_d;
  logic [2:0][7:0] flt_cnt;
  logic [8:0]      prime_cnt;
  logic            primed;

  logic a_chg;
  logic b_chg;
  logic illegal;
  logic cnt_evt;
  logic fwd;
  logic z_rise;

  always_ff @(posedge CLOCK_50M or negedge RST_n) begin
    if (!RST_n) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= {iA_raw, iB_raw, iZ_raw};
      sync_2 <= sync_1;
    end
  end

  always_ff @(posedge CLOCK_50M or negedge RST_n) begin
    if (!RST_n) begin
      filt    <= '0;
      filt_d  <= '0;
      flt_cnt <= '0;
    end else begin
      filt_d <= filt;
      for (int i = 0; i < 3; i++) begin
        if (sync_2[i] != filt[i]) begin
          if (flt_cnt[i] == FLT_LAST) begin
            filt[i]    <= sync_2[i];
            flt_cnt[i] <= '0;
          end else begin
            flt_cnt[i] <= flt_cnt[i] + 8'd1;
          end
        end else begin
          flt_cnt[i] <= '0;
        end
      end
    end
  end

  // Priming outlasts the first filter pass so levels already high at reset never strobe.
  always_ff @(posedge CLOCK_50M or negedge RST_n) begin
    if (!RST_n) begin
      prime_cnt <= '0;
      primed    <= 1'b0;
    end else if (!primed) begin
      if (prime_cnt == PRIME_LAST) begin
        primed <= 1'b1;
      end else begin
        prime_cnt <= prime_cnt + 9'd1;
      end
    end
  end

  always_comb begin
    a_chg   = filt[2] ^ filt_d[2];
    b_chg   = filt[1] ^ filt_d[1];
    illegal = a_chg & b_chg;
    z_rise  = filt[0] & ~filt_d[0];
`ifdef QUAD_X4_EN
    // An A edge is forward when it lands with A != B; a B edge when it lands with A == B.
    cnt_evt = a_chg ^ b_chg;
    fwd     = a_chg ? (filt[2] ^ filt[1]) : ~(filt[2] ^ filt[1]);
`else
    cnt_evt = filt[2] & ~filt_d[2] & ~b_chg;
    fwd     = ~filt[1];
`endif
  end

  always_ff @(posedge CLOCK_50M or negedge RST_n) begin
    if (!RST_n) begin
      oPulseA   <= 1'b0;
      oPulseZ   <= 1'b0;
      oDir      <= 1'b0;
      oPosition <= '0;
      oQuadErr  <= 1'b0;
    end else begin
      oPulseA <= primed & cnt_evt;
      oPulseZ <= primed & z_rise;
      if (primed && cnt_evt) begin
        oDir <= fwd;
      end
      if (iClear) begin
        oPosition <= '0;
      end else if (Z_CLR && primed && z_rise) begin
        oPosition <= '0;
      end else if (primed && cnt_evt) begin
        oPosition <= fwd ? oPosition + POS_W'(1) : oPosition - POS_W'(1);
      end
      if (iClear) begin
        oQuadErr <= 1'b0;
      end else if (primed && illegal) begin
        oQuadErr <= 1'b1;
      end
    end
  end

  assign oLevelABZ = filt;

endmodule
